// File: rtl/weight_loader.sv
// weight_loader: packs a host word stream into storage rows and writes
// them out in order, row by row within a layer, then layer by layer.
// Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN adds a running
// modulo-2^data_size sum of every accepted word on port checksum.
module weight_loader #(
    parameter int data_size  = 16,
    parameter int size       = 3,
    parameter int layer_size = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [data_size-1:0]      in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [31:0]               write_layer_index,
    output logic [31:0]               write_row_index,
    output logic [data_size*size-1:0] write_data,
    output logic                      is_write,
    output logic                      busy,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output logic [data_size-1:0]      checksum,
`endif
    output logic                      done
);

    localparam int CW = (size > 1) ? $clog2(size) : 1;
    localparam int LW = (layer_size > 1) ? $clog2(layer_size) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   col_q, col_d;
    logic [CW-1:0]                   row_q, row_d;
    logic [LW-1:0]                   layer_q, layer_d;
    logic [size-1:0][data_size-1:0]  buf_q, buf_d;
    logic [data_size*size-1:0]       wdata_q, wdata_d;
    logic [31:0]                     wlayer_q, wlayer_d;
    logic [31:0]                     wrow_q, wrow_d;
    logic                            in_ready_q, in_ready_d;
    logic                            is_write_q, is_write_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [data_size-1:0]            csum_q, csum_d;
`endif

    // Next-state logic; outputs are decoded from the next state so they are
    // registered and line up with the state they describe.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        layer_d  = layer_q;
        buf_d    = buf_q;
        wdata_d  = wdata_q;
        wlayer_d = wlayer_q;
        wrow_d   = wrow_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    col_d   = '0;
                    row_d   = '0;
                    layer_d = '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LOAD: begin
                if (in_valid) begin
                    buf_d[col_q] = in_data;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                    csum_d = csum_q + in_data;
`endif
                    if (col_q == CW'(size - 1)) begin
                        col_d   = '0;
                        state_d = WRITE;
                        // column 0 lands in the most significant slot
                        for (int c = 0; c < size; c++)
                            wdata_d[(size-c)*data_size-1 -: data_size] = buf_d[c];
                        wlayer_d = 32'(layer_q);
                        wrow_d   = 32'(row_q);
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (row_q == CW'(size - 1)) begin
                    if (layer_q == LW'(layer_size - 1)) begin
                        state_d = DONE;
                    end else begin
                        row_d   = '0;
                        layer_d = layer_q + 1'b1;
                        state_d = LOAD;
                    end
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == LOAD);
        is_write_d = (state_d == WRITE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    // State and output registers; reset drops everything, including any
    // partially assembled row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            layer_q    <= '0;
            buf_q      <= '0;
            wdata_q    <= '0;
            wlayer_q   <= '0;
            wrow_q     <= '0;
            in_ready_q <= 1'b0;
            is_write_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            layer_q    <= layer_d;
            buf_q      <= buf_d;
            wdata_q    <= wdata_d;
            wlayer_q   <= wlayer_d;
            wrow_q     <= wrow_d;
            in_ready_q <= in_ready_d;
            is_write_q <= is_write_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign in_ready          = in_ready_q;
    assign is_write          = is_write_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign write_data        = wdata_q;
    assign write_layer_index = wlayer_q;
    assign write_row_index   = wrow_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    assign checksum          = csum_q;
`endif

endmodule
